// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and register-file parameter defaults.
package cpu_types_pkg;

  localparam int unsigned NREAD_DEF = 2;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned AW_DEF    = 5;
  localparam int unsigned CW_DEF    = 2;

  typedef logic [DW_DEF-1:0] word_t;
  typedef logic [AW_DEF-1:0] regbits_t;

  function automatic int unsigned nreg(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/id_regfile_sb_if.sv
// Decode-stage register file bus: read ports, writeback, issue/kill tracking.
interface id_regfile_sb_if
  import cpu_types_pkg::*;
#(
  parameter int unsigned NREAD = NREAD_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned AW    = AW_DEF
);

  logic [NREAD-1:0][AW-1:0] rsel;
  logic [NREAD-1:0][DW-1:0] rdat;
  logic [NREAD-1:0]         rbusy;
  logic                     wen_wb;
  logic [AW-1:0]            wsel_wb;
  logic [DW-1:0]            wdat_wb;
  logic                     jal_wb;
  logic [DW-1:0]            npc_wb;
  logic                     iss_en;
  logic [AW-1:0]            iss_dst;
  logic                     kill_en;
  logic [AW-1:0]            kill_dst;
  logic                     iss_full;

  modport master (
    output rsel, wen_wb, wsel_wb, wdat_wb, jal_wb, npc_wb, iss_en, iss_dst, kill_en, kill_dst,
    input  rdat, rbusy, iss_full
  );

  modport slave (
    input  rsel, wen_wb, wsel_wb, wdat_wb, jal_wb, npc_wb, iss_en, iss_dst, kill_en, kill_dst,
    output rdat, rbusy, iss_full
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-writer counters; drives operand busy and issue-stall flags.
module reg_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int unsigned NREAD = NREAD_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_dst,
  input  logic                     kill_en,
  input  logic [AW-1:0]            kill_dst,
  input  logic                     wen,
  input  logic [AW-1:0]            wsel,
  input  logic [NREAD-1:0][AW-1:0] rsel,
  output logic [NREAD-1:0]         rbusy,
  output logic                     iss_full
);

  localparam int unsigned NREG = nreg(AW);
  localparam logic [CW-1:0] CntMax = '1;

  logic [CW-1:0]   cnt_q [NREG];
  logic [CW-1:0]   cnt_d [NREG];
  logic [NREG-1:0] busy;
  logic            inc;
  logic [1:0]      dec;
  logic [CW+1:0]   sum;
  logic [CW+1:0]   dec_w;

  always_comb begin
    iss_full = iss_en && (iss_dst != '0) && (cnt_q[iss_dst] == CntMax);
  end

  // Arithmetic is widened by two bits so net decrement can clamp at zero.
  always_comb begin
    inc   = 1'b0;
    dec   = '0;
    sum   = '0;
    dec_w = '0;
    busy  = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = '0;
    end
    for (int r = 1; r < NREG; r++) begin
      inc   = iss_en && (iss_dst == AW'(r)) && !iss_full;
      dec   = 2'(wen && (wsel == AW'(r))) + 2'(kill_en && (kill_dst == AW'(r)));
      sum   = (CW+2)'(cnt_q[r]) + (CW+2)'(inc);
      dec_w = (CW+2)'(dec);
      cnt_d[r] = (sum > dec_w) ? CW'(sum - dec_w) : '0;
      busy[r]  = (CW+2)'(cnt_q[r]) > dec_w;
    end
  end

  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rbusy[i] = busy[rsel[i]];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

endmodule

// File: rtl/id_regfile_sb.sv
// Decode register file with writeback bypass, jal link mux and pending-writer scoreboard.
module id_regfile_sb
  import cpu_types_pkg::*;
#(
  parameter int unsigned NREAD = NREAD_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input logic            CLK,
  input logic            RST,
  id_regfile_sb_if.slave bus
);

  localparam int unsigned NREG = nreg(AW);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] wval;

  always_comb begin
    wval = bus.jal_wb ? bus.npc_wb : bus.wdat_wb;
  end

  // Register 0 is never written, so its storage stays at the reset value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else if (bus.wen_wb && (bus.wsel_wb != '0)) begin
      regs_q[bus.wsel_wb] <= wval;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    assign bus.rdat[i] = (bus.rsel[i] == '0)                           ? '0   :
                         (bus.wen_wb && (bus.wsel_wb == bus.rsel[i])) ? wval :
                                                                        regs_q[bus.rsel[i]];
  end

  reg_scoreboard #(
    .NREAD (NREAD),
    .AW    (AW),
    .CW    (CW)
  ) u_sb (
    .CLK      (CLK),
    .RST      (RST),
    .iss_en   (bus.iss_en),
    .iss_dst  (bus.iss_dst),
    .kill_en  (bus.kill_en),
    .kill_dst (bus.kill_dst),
    .wen      (bus.wen_wb),
    .wsel     (bus.wsel_wb),
    .rsel     (bus.rsel),
    .rbusy    (bus.rbusy),
    .iss_full (bus.iss_full)
  );

endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed self-checking bench for id_regfile_sb.
module tb_id_regfile_sb;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  id_regfile_sb_if #(.NREAD(2), .DW(32), .AW(5)) bus ();

  id_regfile_sb #(
    .NREAD (2),
    .DW    (32),
    .AW    (5),
    .CW    (2)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wen_wb   = 1'b0;
    bus.wsel_wb  = '0;
    bus.wdat_wb  = '0;
    bus.jal_wb   = 1'b0;
    bus.npc_wb   = '0;
    bus.iss_en   = 1'b0;
    bus.iss_dst  = '0;
    bus.kill_en  = 1'b0;
    bus.kill_dst = '0;
  endtask

  task automatic issue(input regbits_t dst);
    bus.iss_en  = 1'b1;
    bus.iss_dst = dst;
  endtask

  task automatic wb(input regbits_t dst, input word_t val);
    bus.wen_wb  = 1'b1;
    bus.wsel_wb = dst;
    bus.wdat_wb = val;
  endtask

  initial begin
    idle();
    bus.rsel = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.rsel[0] = 5'd3;
    bus.rsel[1] = 5'd17;
    #1;
    check("reset_rdat0", 64'(bus.rdat[0]), 64'h0);
    check("reset_rdat1", 64'(bus.rdat[1]), 64'h0);
    check("reset_rbusy", 64'(bus.rbusy), 64'h0);
    check("reset_full", 64'(bus.iss_full), 64'h0);

    // Write with same-cycle bypass, then from storage
    wb(5'd5, 32'hDEADBEEF);
    bus.rsel[0] = 5'd5;
    #1;
    check("bypass_r5", 64'(bus.rdat[0]), 64'hDEADBEEF);
    tick();
    idle();
    #1;
    check("store_r5", 64'(bus.rdat[0]), 64'hDEADBEEF);

    // jal writes the link value
    wb(5'd31, 32'h0);
    bus.jal_wb  = 1'b1;
    bus.npc_wb  = 32'h00000104;
    bus.rsel[1] = 5'd31;
    #1;
    check("jal_bypass", 64'(bus.rdat[1]), 64'h104);
    tick();
    idle();
    #1;
    check("jal_store", 64'(bus.rdat[1]), 64'h104);

    // Register 0 ignores write and issue
    wb(5'd0, 32'h1234);
    issue(5'd0);
    bus.rsel[0] = 5'd0;
    #1;
    check("r0_bypass", 64'(bus.rdat[0]), 64'h0);
    check("r0_full", 64'(bus.iss_full), 64'h0);
    tick();
    idle();
    #1;
    check("r0_store", 64'(bus.rdat[0]), 64'h0);
    check("r0_busy", 64'(bus.rbusy[0]), 64'h0);

    // Saturate reg 8's counter
    bus.rsel[0] = 5'd8;
    issue(5'd8);
    #1;
    check("r8_iss1_notbusy", 64'(bus.rbusy[0]), 64'h0);
    check("r8_iss1_full", 64'(bus.iss_full), 64'h0);
    tick();
    tick();
    #1;
    check("r8_iss3_full", 64'(bus.iss_full), 64'h0);
    tick();
    idle();
    #1;
    check("r8_busy3", 64'(bus.rbusy[0]), 64'h1);
    issue(5'd8);
    #1;
    check("r8_iss4_full", 64'(bus.iss_full), 64'h1);
    tick();
    idle();
    #1;
    check("r8_full_idle", 64'(bus.iss_full), 64'h0);
    wb(5'd8, 32'hA1);
    #1;
    check("r8_wb1_busy", 64'(bus.rbusy[0]), 64'h1);
    tick();
    wb(5'd8, 32'hA2);
    #1;
    check("r8_wb2_busy", 64'(bus.rbusy[0]), 64'h1);
    tick();
    wb(5'd8, 32'hA3);
    #1;
    check("r8_wb3_busy", 64'(bus.rbusy[0]), 64'h0);
    check("r8_wb3_rdat", 64'(bus.rdat[0]), 64'hA3);
    tick();
    idle();
    #1;
    check("r8_after_busy", 64'(bus.rbusy[0]), 64'h0);

    // Issue, writeback and kill on reg 9 in one cycle
    issue(5'd9);
    tick();
    idle();
    bus.rsel[0] = 5'd9;
    #1;
    check("r9_busy1", 64'(bus.rbusy[0]), 64'h1);
    issue(5'd9);
    wb(5'd9, 32'h99);
    bus.kill_en  = 1'b1;
    bus.kill_dst = 5'd9;
    #1;
    check("r9_triple_busy", 64'(bus.rbusy[0]), 64'h0);
    check("r9_triple_full", 64'(bus.iss_full), 64'h0);
    tick();
    idle();
    #1;
    check("r9_after_busy", 64'(bus.rbusy[0]), 64'h0);

    // Decrement on an idle counter clamps at zero
    bus.rsel[0] = 5'd10;
    wb(5'd10, 32'h10);
    bus.kill_en  = 1'b1;
    bus.kill_dst = 5'd10;
    tick();
    idle();
    issue(5'd10);
    tick();
    idle();
    #1;
    check("r10_busy1", 64'(bus.rbusy[0]), 64'h1);
    wb(5'd10, 32'h11);
    #1;
    check("r10_clamp_busy", 64'(bus.rbusy[0]), 64'h0);
    tick();
    idle();
    #1;
    check("r10_after_busy", 64'(bus.rbusy[0]), 64'h0);

    // Kill alone retires the writer
    issue(5'd11);
    tick();
    idle();
    bus.rsel[1] = 5'd11;
    #1;
    check("r11_busy1", 64'(bus.rbusy[1]), 64'h1);
    bus.kill_en  = 1'b1;
    bus.kill_dst = 5'd11;
    #1;
    check("r11_kill_busy", 64'(bus.rbusy[1]), 64'h0);
    tick();
    idle();
    #1;
    check("r11_after_busy", 64'(bus.rbusy[1]), 64'h0);

    // Reset overrides same-cycle write and issue
    issue(5'd12);
    tick();
    tick();
    idle();
    bus.rsel[0] = 5'd12;
    bus.rsel[1] = 5'd5;
    #1;
    check("pre_rst_busy", 64'(bus.rbusy[0]), 64'h1);
    check("pre_rst_r5", 64'(bus.rdat[1]), 64'hDEADBEEF);
    rst = 1'b1;
    wb(5'd12, 32'hCAFEF00D);
    issue(5'd12);
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("post_rst_r12", 64'(bus.rdat[0]), 64'h0);
    check("post_rst_busy", 64'(bus.rbusy), 64'h0);
    check("post_rst_r5", 64'(bus.rdat[1]), 64'h0);
    bus.rsel[1] = 5'd31;
    #1;
    check("post_rst_r31", 64'(bus.rdat[1]), 64'h0);
    check("post_rst_full", 64'(bus.iss_full), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
